// File: rtl/cd_csr_pkg.sv
// Shared definitions for the CDBUS CSR block: register map, reset defaults
// and int_flag bit positions.
package cd_csr_pkg;

  localparam logic [4:0] REG_VERSION         = 5'h00;
  localparam logic [4:0] REG_SETTING         = 5'h02;
  localparam logic [4:0] REG_IDLE_WAIT_LEN   = 5'h04;
  localparam logic [4:0] REG_TX_PERMIT_LEN_L = 5'h05;
  localparam logic [4:0] REG_TX_PERMIT_LEN_H = 5'h06;
  localparam logic [4:0] REG_MAX_IDLE_LEN_L  = 5'h07;
  localparam logic [4:0] REG_MAX_IDLE_LEN_H  = 5'h08;
  localparam logic [4:0] REG_TX_PRE_LEN      = 5'h09;
  localparam logic [4:0] REG_FILTER          = 5'h0b;
  localparam logic [4:0] REG_DIV_LS_L        = 5'h0c;
  localparam logic [4:0] REG_DIV_LS_H        = 5'h0d;
  localparam logic [4:0] REG_DIV_HS_L        = 5'h0e;
  localparam logic [4:0] REG_DIV_HS_H        = 5'h0f;
  localparam logic [4:0] REG_INT_FLAG        = 5'h10;
  localparam logic [4:0] REG_INT_MASK        = 5'h11;
  localparam logic [4:0] REG_RX              = 5'h14;
  localparam logic [4:0] REG_TX              = 5'h15;
  localparam logic [4:0] REG_RX_CTRL         = 5'h16;
  localparam logic [4:0] REG_TX_CTRL         = 5'h17;
  localparam logic [4:0] REG_RX_ADDR         = 5'h18;
  localparam logic [4:0] REG_RX_PAGE_FLAG    = 5'h19;
  localparam logic [4:0] REG_FILTER1         = 5'h1a;

  // setting = {full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull}
  localparam logic [6:0] RST_SETTING       = 7'h10;
  localparam logic [7:0] RST_IDLE_WAIT_LEN = 8'd10;
  localparam logic [9:0] RST_TX_PERMIT_LEN = 10'd20;
  localparam logic [9:0] RST_MAX_IDLE_LEN  = 10'd200;
  localparam logic [1:0] RST_TX_PRE_LEN    = 2'd1;
  localparam logic [7:0] RST_FILTER        = 8'hff;

  localparam int IF_BUS_IDLE   = 0;
  localparam int IF_RX_PENDING = 1;
  localparam int IF_RX_BREAK   = 2;
  localparam int IF_RX_LOST    = 3;
  localparam int IF_RX_ERR     = 4;
  localparam int IF_TX_DONE    = 5;
  localparam int IF_CD         = 6;
  localparam int IF_TX_ERR     = 7;

  // filter 0 lives in the legacy slot, the rest are appended from 0x1a
  function automatic logic [4:0] filter_addr(input int idx);
    return (idx == 0) ? REG_FILTER : 5'(int'(REG_FILTER1) + idx - 1);
  endfunction

endpackage

// File: rtl/cd_irq_flags.sv
// Sticky interrupt flag bank with W1C clear, tx-done edge detect, mask and
// registered irq. A set landing with a clear in the same cycle wins.
module cd_irq_flags
  import cd_csr_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx_error,
  input  logic       i_rx_ram_lost,
  input  logic       i_rx_break,
  input  logic       i_cd,
  input  logic       i_tx_err,
  input  logic       i_tx_pending,
  input  logic       i_rx_pending,
  input  logic       i_bus_idle,
  input  logic [7:2] i_clr,
  input  logic       i_mask_we,
  input  logic [7:0] i_mask_wdata,
  output logic [7:0] o_int_flag,
  output logic [7:0] o_int_mask,
  output logic       o_irq
);

  logic [7:2] r_sticky;
  logic [7:0] r_mask;
  logic       r_tx_pending_d;
  logic       r_irq;
  logic [7:2] w_set;

  always_comb begin
    w_set              = '0;
    w_set[IF_RX_BREAK] = i_rx_break;
    w_set[IF_RX_LOST]  = i_rx_ram_lost;
    w_set[IF_RX_ERR]   = i_rx_error;
    w_set[IF_TX_DONE]  = r_tx_pending_d & ~i_tx_pending;
    w_set[IF_CD]       = i_cd;
    w_set[IF_TX_ERR]   = i_tx_err;
  end

  assign o_int_flag = {r_sticky, i_rx_pending, i_bus_idle};
  assign o_int_mask = r_mask;
  assign o_irq      = r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky       <= '0;
      r_mask         <= '0;
      r_tx_pending_d <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_sticky       <= (r_sticky & ~i_clr) | w_set;
      r_tx_pending_d <= i_tx_pending;
      r_irq          <= |(o_int_flag & r_mask);
      if (i_mask_we) r_mask <= i_mask_wdata;
    end
  end

endmodule

// File: rtl/cd_csr_gen.sv
// CDBUS control/status registers between the host Avalon-MM port and the
// cd_rx/cd_tx datapaths; read data returns one cycle after the read strobe.
module cd_csr_gen
  import cd_csr_pkg::*;
#(
  parameter logic [7:0]  VERSION  = 8'd12,
  parameter logic [15:0] DIV_LS   = 16'd346,
  parameter logic [15:0] DIV_HS   = 16'd346,
  parameter int          N_FILTER = 3,
  parameter int          RAM_AW   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  irq,
  input  logic [4:0]            csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [7:0]            csr_writedata,
  output logic [7:0]            csr_readdata,
  output logic                  csr_readdatavalid,
  output logic                  full_duplex,
  output logic                  break_sync,
  output logic                  arbitration,
  output logic                  not_drop,
  output logic                  user_crc,
  output logic                  tx_invert,
  output logic                  tx_push_pull,
  output logic [7:0]            idle_wait_len,
  output logic [9:0]            tx_permit_len,
  output logic [9:0]            max_idle_len,
  output logic [1:0]            tx_pre_len,
  output logic [8*N_FILTER-1:0] filters,
  output logic [15:0]           div_ls,
  output logic [15:0]           div_hs,
  output logic [RAM_AW-1:0]     rx_ram_rd_addr,
  input  logic [7:0]            rx_ram_rd_byte,
  input  logic [7:0]            rx_ram_rd_flags,
  output logic                  rx_ram_rd_done,
  output logic                  rx_clean_all,
  output logic                  tx_ram_switch,
  output logic                  tx_abort,
  input  logic                  rx_error,
  input  logic                  rx_ram_lost,
  input  logic                  rx_break,
  input  logic                  cd,
  input  logic                  tx_err,
  input  logic                  rx_pending,
  input  logic                  bus_idle,
  input  logic                  tx_pending,
  output logic                  tx_ram_wr_en,
  output logic [RAM_AW-1:0]     tx_ram_wr_addr,
  output logic                  has_break,
  input  logic                  ack_break
);

  logic                  r_rd_valid;
  logic [4:0]            r_rd_sel;
  logic [6:0]            r_setting;
  logic [7:0]            r_idle_wait_len;
  logic [9:0]            r_tx_permit_len;
  logic [9:0]            r_max_idle_len;
  logic [1:0]            r_tx_pre_len;
  logic [8*N_FILTER-1:0] r_filters;
  logic [15:0]           r_div_ls;
  logic [15:0]           r_div_hs;
  logic [RAM_AW-1:0]     r_rx_addr;
  logic [RAM_AW-1:0]     r_tx_addr;
  logic                  r_rx_ram_rd_done;
  logic                  r_rx_clean_all;
  logic                  r_tx_ram_switch;
  logic                  r_tx_abort;
  logic                  r_has_break;

  logic                  w_rd;
  logic                  w_set_break;
  logic [7:2]            w_clr;
  logic [7:0]            w_int_flag;
  logic [7:0]            w_int_mask;
  logic [7:0]            w_rd_data;

  // a simultaneous read and write performs only the write
  assign w_rd        = csr_read & ~csr_write;
  assign w_set_break = csr_write && csr_address == REG_TX_CTRL && csr_writedata[5];

  always_comb begin
    w_clr = '0;
    if (csr_write) begin
      if (csr_address == REG_INT_FLAG) w_clr = csr_writedata[7:2];
      if (csr_address == REG_RX_CTRL) begin
        w_clr[IF_RX_LOST]  = csr_writedata[2];
        w_clr[IF_RX_ERR]   = csr_writedata[3];
        w_clr[IF_RX_BREAK] = csr_writedata[5];
      end
      if (csr_address == REG_TX_CTRL) begin
        w_clr[IF_CD]     = csr_writedata[2];
        w_clr[IF_TX_ERR] = csr_writedata[3];
      end
    end
  end

  cd_irq_flags u_irq_flags (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_rx_error    (rx_error),
    .i_rx_ram_lost (rx_ram_lost),
    .i_rx_break    (rx_break),
    .i_cd          (cd),
    .i_tx_err      (tx_err),
    .i_tx_pending  (tx_pending),
    .i_rx_pending  (rx_pending),
    .i_bus_idle    (bus_idle),
    .i_clr         (w_clr),
    .i_mask_we     (csr_write && csr_address == REG_INT_MASK),
    .i_mask_wdata  (csr_writedata),
    .o_int_flag    (w_int_flag),
    .o_int_mask    (w_int_mask),
    .o_irq         (irq)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid       <= 1'b0;
      r_rd_sel         <= '0;
      r_setting        <= RST_SETTING;
      r_idle_wait_len  <= RST_IDLE_WAIT_LEN;
      r_tx_permit_len  <= RST_TX_PERMIT_LEN;
      r_max_idle_len   <= RST_MAX_IDLE_LEN;
      r_tx_pre_len     <= RST_TX_PRE_LEN;
      r_filters        <= {N_FILTER{RST_FILTER}};
      r_div_ls         <= DIV_LS;
      r_div_hs         <= DIV_HS;
      r_rx_addr        <= '0;
      r_tx_addr        <= '0;
      r_rx_ram_rd_done <= 1'b0;
      r_rx_clean_all   <= 1'b0;
      r_tx_ram_switch  <= 1'b0;
      r_tx_abort       <= 1'b0;
      r_has_break      <= 1'b0;
    end else begin
      r_rd_valid       <= w_rd;
      r_rx_ram_rd_done <= 1'b0;
      r_rx_clean_all   <= 1'b0;
      r_tx_ram_switch  <= 1'b0;
      r_tx_abort       <= 1'b0;
      if (w_rd) r_rd_sel <= csr_address;
      // the RAM latches the pre-increment address on this same edge
      if (w_rd && csr_address == REG_RX) r_rx_addr <= r_rx_addr + RAM_AW'(1);
      if (csr_write) begin
        case (csr_address)
          REG_SETTING:         r_setting <= csr_writedata[6:0];
          REG_IDLE_WAIT_LEN:   r_idle_wait_len <= csr_writedata;
          REG_TX_PERMIT_LEN_L: r_tx_permit_len[7:0] <= csr_writedata;
          REG_TX_PERMIT_LEN_H: r_tx_permit_len[9:8] <= csr_writedata[1:0];
          REG_MAX_IDLE_LEN_L:  r_max_idle_len[7:0] <= csr_writedata;
          REG_MAX_IDLE_LEN_H:  r_max_idle_len[9:8] <= csr_writedata[1:0];
          REG_TX_PRE_LEN:      r_tx_pre_len <= csr_writedata[1:0];
          REG_DIV_LS_L:        r_div_ls[7:0] <= csr_writedata;
          REG_DIV_LS_H:        r_div_ls[15:8] <= csr_writedata;
          REG_DIV_HS_L:        r_div_hs[7:0] <= csr_writedata;
          REG_DIV_HS_H:        r_div_hs[15:8] <= csr_writedata;
          REG_TX:              r_tx_addr <= r_tx_addr + RAM_AW'(1);
          REG_RX_ADDR:         r_rx_addr <= RAM_AW'(csr_writedata);
          REG_RX_CTRL: begin
            if (csr_writedata[0]) r_rx_addr <= '0;
            r_rx_ram_rd_done <= csr_writedata[1];
            r_rx_clean_all   <= csr_writedata[4];
          end
          REG_TX_CTRL: begin
            if (csr_writedata[0]) r_tx_addr <= '0;
            r_tx_ram_switch <= csr_writedata[1];
            r_tx_abort      <= csr_writedata[4];
          end
          default: ;
        endcase
      end
      for (int i = 0; i < N_FILTER; i++) begin
        if (csr_write && csr_address == filter_addr(i)) r_filters[8*i +: 8] <= csr_writedata;
      end
      if (w_set_break)    r_has_break <= 1'b1;
      else if (ack_break) r_has_break <= 1'b0;
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (r_rd_sel)
      REG_VERSION:         w_rd_data = VERSION;
      REG_SETTING:         w_rd_data = {1'b0, r_setting};
      REG_IDLE_WAIT_LEN:   w_rd_data = r_idle_wait_len;
      REG_TX_PERMIT_LEN_L: w_rd_data = r_tx_permit_len[7:0];
      REG_TX_PERMIT_LEN_H: w_rd_data = {6'b0, r_tx_permit_len[9:8]};
      REG_MAX_IDLE_LEN_L:  w_rd_data = r_max_idle_len[7:0];
      REG_MAX_IDLE_LEN_H:  w_rd_data = {6'b0, r_max_idle_len[9:8]};
      REG_TX_PRE_LEN:      w_rd_data = {6'b0, r_tx_pre_len};
      REG_DIV_LS_L:        w_rd_data = r_div_ls[7:0];
      REG_DIV_LS_H:        w_rd_data = r_div_ls[15:8];
      REG_DIV_HS_L:        w_rd_data = r_div_hs[7:0];
      REG_DIV_HS_H:        w_rd_data = r_div_hs[15:8];
      REG_INT_FLAG:        w_rd_data = w_int_flag;
      REG_INT_MASK:        w_rd_data = w_int_mask;
      REG_RX:              w_rd_data = rx_ram_rd_byte;
      REG_RX_ADDR:         w_rd_data = 8'(r_rx_addr);
      REG_RX_PAGE_FLAG:    w_rd_data = rx_ram_rd_flags;
      default:             w_rd_data = '0;
    endcase
    for (int i = 0; i < N_FILTER; i++) begin
      if (r_rd_sel == filter_addr(i)) w_rd_data = r_filters[8*i +: 8];
    end
  end

  assign csr_readdata      = r_rd_valid ? w_rd_data : 8'h00;
  assign csr_readdatavalid = r_rd_valid;

  assign {full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull} = r_setting;
  assign idle_wait_len  = r_idle_wait_len;
  assign tx_permit_len  = r_tx_permit_len;
  assign max_idle_len   = r_max_idle_len;
  assign tx_pre_len     = r_tx_pre_len;
  assign filters        = r_filters;
  assign div_ls         = r_div_ls;
  assign div_hs         = r_div_hs;
  assign rx_ram_rd_addr = r_rx_addr;
  assign tx_ram_wr_addr = r_tx_addr;
  assign rx_ram_rd_done = r_rx_ram_rd_done;
  assign rx_clean_all   = r_rx_clean_all;
  assign tx_ram_switch  = r_tx_ram_switch;
  assign tx_abort       = r_tx_abort;
  assign has_break      = r_has_break;
  assign tx_ram_wr_en   = csr_write && csr_address == REG_TX;

endmodule
